// File: rtl/cbrt_feeder_pkg.sv
// Shared constants and FSM encoding for the cube-root stream front-end.
package cbrt_feeder_pkg;

  localparam int unsigned OpWidth      = 8;
  localparam int unsigned RootWidth    = 4;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefTimeout   = 255;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitAck,
    StWaitDone,
    StOut
  } state_e;

endpackage

// File: rtl/op_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit so full and empty are unambiguous.
module op_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      wptr_q, rptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  // Status flags from pointer comparison; requests are gated so misuse cannot corrupt state.
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
              (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    rdata_o = mem_q[rptr_q[PtrW-1:0]];
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cbrt_feeder.sv
// Stream front-end: buffers operands, issues them one at a time to the iterative
// cube-root unit and returns each root with its operand on an output stream.
module cbrt_feeder
  import cbrt_feeder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic [OpWidth-1:0]   in_data_i,
  output logic                 in_ready_o,
  output logic [OpWidth-1:0]   cbrt_a_o,
  output logic                 cbrt_start_o,
  input  logic [1:0]           cbrt_busy_i,
  input  logic [RootWidth-1:0] cbrt_y_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OpWidth-1:0]   out_a_o,
  output logic [RootWidth-1:0] out_y_o,
  output logic                 out_err_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Last count value before the wait budget is exhausted.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic [OpWidth-1:0]     a_q, a_d;
  logic                   out_valid_q, out_valid_d;
  logic [OpWidth-1:0]     out_a_q, out_a_d;
  logic [RootWidth-1:0]   out_y_q, out_y_d;
  logic                   out_err_q, out_err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [OpWidth-1:0]     fifo_head;
  logic                   cnt_hit, unit_busy;

  op_fifo #(
    .Width (OpWidth),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (in_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Input handshake; a full FIFO refuses input even while it pops.
  always_comb begin
    in_ready_o = !fifo_full && rst_ni;
    fifo_push  = in_valid_i && in_ready_o;
  end

  // Next-state logic for the issue/wait/present sequence.
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_y_d     = out_y_q;
    out_err_d   = out_err_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    cnt_hit     = (cnt_q >= CntLast);
    unit_busy   = (cbrt_busy_i != 2'b00);

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          a_d      = fifo_head;
          start_d  = 1'b1;
          cnt_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (unit_busy) begin
          state_d = StWaitDone;
        end else if (cnt_hit) begin
          // Unit never acknowledged: force an error result and move on.
          out_y_d     = '0;
          out_a_d     = a_q;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!unit_busy) begin
          out_y_d     = cbrt_y_i;
          out_a_d     = a_q;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end else if (cnt_hit) begin
          out_y_d     = '0;
          out_a_d     = a_q;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight or held result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_y_q     <= '0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_y_q     <= out_y_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    cbrt_a_o     = a_q;
    cbrt_start_o = start_q;
    out_valid_o  = out_valid_q;
    out_a_o      = out_a_q;
    out_y_o      = out_y_q;
    out_err_o    = out_err_q;
    busy_o       = !fifo_empty || (state_q != StIdle);
  end

endmodule

// File: tb/tb_cbrt_feeder.sv
// Scoreboard bench for cbrt_feeder with a behavioural cube-root unit beside it.
module tb_cbrt_feeder;

  localparam int unsigned Lat = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] y;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] cbrt_a;
  logic       cbrt_start;
  logic [1:0] m_busy;
  logic [3:0] m_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [3:0] out_y;
  logic       out_err;
  logic       busy;

  logic       ready_en;
  logic       dead;
  int         hold_left = 20;
  int         m_left;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_results = 0;
  int         n_starts = 0;
  int         n_hold = 0;
  logic       prev_start, prev_valid;
  logic [1:0] prev_busy, prev2_busy;

  int         w;
  logic       st;
  int         s0, r0, n;

  always #5 clk = ~clk;

  assign out_ready = ready_en && !(out_valid && out_a == 8'd64 && hold_left != 0);

  cbrt_feeder #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (10)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .cbrt_a_o     (cbrt_a),
    .cbrt_start_o (cbrt_start),
    .cbrt_busy_i  (m_busy),
    .cbrt_y_i     (m_y),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_a_o      (out_a),
    .out_y_o      (out_y),
    .out_err_o    (out_err),
    .busy_o       (busy)
  );

  function automatic int unsigned icbrt(input int unsigned a);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural cube-root unit: busy rises the cycle after start is sampled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 2'b00;
      m_y    <= 4'd0;
      m_left <= 0;
    end else if (m_busy != 2'b00) begin
      if (m_left <= 1) m_busy <= 2'b00;
      else m_left <= m_left - 1;
    end else if (cbrt_start && !dead) begin
      m_busy <= {1'b1, cbrt_a[0]};
      m_left <= Lat;
      m_y    <= 4'(icbrt(cbrt_a));
    end
  end

  // Backpressure window on the first result for operand 64.
  always @(posedge clk) begin
    if (out_valid && out_a == 8'd64 && hold_left > 0) hold_left <= hold_left - 1;
  end

  // Monitor: predicts handshakes at the negedge before the edge that takes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_start = 1'b0;
      prev_valid = 1'b0;
      prev_busy  = 2'b00;
      prev2_busy = 2'b00;
    end else begin
      if (in_valid && in_ready)
        sb.push_back('{a: in_data, y: dead ? 4'd0 : 4'(icbrt(in_data)), err: dead});
      if (out_valid && out_ready) begin
        n_results++;
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_a", out_a, e.a);
          chk("out_y", out_y, e.y);
          chk("out_err", out_err, e.err);
        end
      end
      if (out_valid && !prev_valid && !out_err) begin
        chk("busy_low_before_valid", (prev_busy != 2'b00), 0);
        chk("busy_high_earlier", (prev2_busy != 2'b00), 1);
      end
      if (cbrt_start) begin
        n_starts++;
        chk("start_width", prev_start, 0);
      end
      if (out_valid && !out_ready && out_a == 8'd64) begin
        n_hold++;
        chk("hold_y", out_y, 4);
        chk("hold_no_start", cbrt_start, 0);
      end
      prev_start = cbrt_start;
      prev_valid = out_valid;
      prev2_busy = prev_busy;
      prev_busy  = m_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [7:0] d, output int waits, output logic start_seen);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    start_seen = cbrt_start;
    if (waits >= 200) chk("push_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    int   wt;
    logic sd;
    push_w(d, wt, sd);
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((busy || out_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("idle_reached", (g < 500), 1);
    tick();
  endtask

  task automatic wait_valid();
    int g = 0;
    @(negedge clk);
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("valid_reached", (g < 200), 1);
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    ready_en = 1'b1;
    dead     = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_start", cbrt_start, 0);
    chk("rst_cbrt_a", cbrt_a, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", in_ready, 1);

    // Single operand.
    s0 = n_starts;
    r0 = n_results;
    push(8'd27);
    wait_idle();
    chk("single_starts", n_starts - s0, 1);
    chk("single_results", n_results - r0, 1);

    // Burst behind a held result; full FIFO refuses the push coinciding with a pop.
    s0 = n_starts;
    r0 = n_results;
    ready_en = 1'b0;
    push(8'd1);
    wait_valid();
    push_w(8'd0, w, st);  chk("burst_wait0", w, 0);
    push_w(8'd7, w, st);  chk("burst_wait1", w, 0);
    push_w(8'd8, w, st);  chk("burst_wait2", w, 0);
    push_w(8'd64, w, st); chk("burst_wait3", w, 0);
    fork
      push_w(8'd255, w, st);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("full_refuses", in_ready, 0);
        end
        @(posedge clk);
        #1;
        ready_en = 1'b1;
      end
    join
    chk("recover_wait", w, 5);
    chk("recover_on_pop", st, 1);
    wait_idle();
    chk("burst_results", n_results - r0, 6);
    chk("burst_starts", n_starts - s0, 6);
    chk("hold_cycles", n_hold, 20);

    // Unit never acknowledges: timeout result, then normal service resumes.
    dead = 1'b1;
    r0 = n_results;
    push(8'd100);
    n = 0;
    @(negedge clk);
    while (!cbrt_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, 11);
    chk("timeout_err", out_err, 1);
    wait_idle();
    dead = 1'b0;
    push(8'd125);
    wait_idle();
    chk("timeout_results", n_results - r0, 2);

    // Reset while the unit is working and three operands wait.
    push(8'd200);
    push(8'd201);
    push(8'd202);
    push(8'd203);
    n = 0;
    @(negedge clk);
    while (m_busy == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tick();
    chk("pre_rst_busy", busy, 1);
    r0 = n_results;
    s0 = n_starts;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_start", cbrt_start, 0);
    chk("arst_cbrt_a", cbrt_a, 0);
    chk("arst_out_a", out_a, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("post_rst_results", n_results - r0, 0);
    chk("post_rst_starts", n_starts - s0, 0);
    chk("post_rst_busy", busy, 0);
    push(8'd64);
    wait_idle();
    chk("post_rst_service", n_results - r0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/cbrt_feeder.md
# cbrt_feeder

Stream front-end for the iterative cube-root unit. It accepts 8-bit operands over a valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the cube-root unit's start/busy interface, captures each 4-bit root, and presents it with its operand on an output valid/ready stream. It sits between the operand source and the `cbrt` unit, and consumes `cbrt`'s `y_bo`/`busy_o` directly.

## Interface
- `FIFO_DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255: maximum cycles allowed in WAIT_ACK plus WAIT_DONE before a result is forced with error.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: operand valid.
- `in_data_i` in 8: operand.
- `in_ready_o` out 1: FIFO can accept.
- `cbrt_a_o` out 8: operand driven to the cube-root unit's `a_bi`.
- `cbrt_start_o` out 1: one-cycle start pulse to the cube-root unit.
- `cbrt_busy_i` in 2: the cube-root unit's `busy_o`; nonzero means busy.
- `cbrt_y_i` in 4: the cube-root unit's `y_bo`.
- `out_valid_o` out 1: result valid.
- `out_a_o` out 8: operand that produced the result.
- `out_y_o` out 4: integer cube root, floor(a^(1/3)).
- `out_err_o` out 1: result was forced by timeout; `out_y_o` is 0.
- `busy_o` out 1: FIFO non-empty or FSM not in IDLE.

## Operation
- FIFO push on `in_valid_i && in_ready_o`. `in_ready_o = !full && rst_ni`. There is no push-through-pop when full: a full FIFO refuses input even in a cycle where it pops.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop head into `cbrt_a_o`, set `cbrt_start_o`=1, clear the timeout counter, go to START.
  - START: `cbrt_start_o`←0, go to WAIT_ACK.
  - WAIT_ACK: if `cbrt_busy_i`≠0, go to WAIT_DONE. Otherwise increment the counter.
  - WAIT_DONE: if `cbrt_busy_i`==0, capture `out_y_o`←`cbrt_y_i`, `out_a_o`←`cbrt_a_o`, `out_err_o`←0, `out_valid_o`←1, go to OUT. Otherwise increment the counter.
  - Timeout: in WAIT_ACK or WAIT_DONE, when the counter reaches `TIMEOUT`, set `out_y_o`=0, `out_err_o`=1, `out_valid_o`=1, go to OUT.
  - OUT: hold all `out_*` stable. On `out_ready_i`, clear `out_valid_o` and go to IDLE.
- Only one operand is in flight. No new start is issued until the current result is accepted.
- `cbrt_a_o` holds its value from pop until the next pop; the cube-root unit samples it only on start.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.
- After a timeout, WAIT_ACK and WAIT_DONE are left regardless of later `cbrt_busy_i`. The top level must reset the cube-root unit together with this block.

## Timing
- Reset (async assert, synchronous deassert at top level) values: state IDLE, FIFO empty, `cbrt_start_o`=0, `cbrt_a_o`=0, `out_valid_o`=0, `out_a_o`=0, `out_y_o`=0, `out_err_o`=0, `busy_o`=0, `in_ready_o`=0 while `rst_ni` is low.
- Reset mid-operation discards the FIFO contents and any in-flight or held result. No `out_valid_o` appears for them.
- Push at edge N makes the FIFO non-empty after N. If idle, the pop and `cbrt_start_o`=1 occur at edge N+1.
- `cbrt_start_o` is high for exactly one cycle.
- The cube-root unit raises busy one cycle after it samples start. WAIT_ACK normally lasts 1 cycle.
- The result is registered on the edge after busy is seen low. `out_valid_o` rises the cycle after the unit's busy falls.
- Total latency = unit latency + 4 cycles (pop, START, WAIT_ACK exit, capture) + `out_ready_i` stall.
- Simultaneous push in the same cycle as a pop that empties the FIFO is legal. The FIFO stays at count 1, and the new entry issues on the next IDLE.

## Structure
- Package/header `cbrt_feeder_pkg`:
  - FSM state encodings (IDLE, START, WAIT_ACK, WAIT_DONE, OUT).
  - Default `FIFO_DEPTH` and `TIMEOUT`.
  - Operand width 8 and root width 4 as named constants.
- Sub-module `op_fifo`: synchronous FIFO parameterised by width and depth.
  - Pointers with an extra wrap bit; full/empty derived from them.
  - Same clock and async active-low reset.
- The FSM and output registers live in `cbrt_feeder`. The cube-root unit is instantiated beside it at top level, not inside.

## Test plan
- Single operand 27 with `out_ready_i`=1 and a behavioural cube-root model → one result: `out_a_o`=27, `out_y_o`=3, `out_err_o`=0, with exactly one `cbrt_start_o` pulse.
- Burst of 0, 7, 8, 64, 255 pushed back-to-back → results in order 0, 1, 2, 4, 6. `in_ready_o` drops after 4 pushes and recovers after the first pop.
- Hold `out_ready_i`=0 for 20 cycles on result 64 → `out_*` stable at 64/4. No new `cbrt_start_o` until accepted.
- Model never raises busy, `TIMEOUT`=10 → `out_valid_o` with `out_err_o`=1 and `out_y_o`=0 after 10 cycles in WAIT_ACK. The next operand then issues normally.
- Assert `rst_ni`=0 during WAIT_DONE with 3 entries queued → all outputs reset immediately and asynchronously. No results are produced for the discarded operands, and `busy_o`=0.
- Push into full FIFO on the same cycle as a pop → push refused. The data is accepted on the following cycle, and no operand is lost or duplicated.
